// File: rtl/pacman_direction_ctrl.sv
// Turn-request front end for the Pacman mover: frame-rate button debounce,
// buffered turn request, wall-gated commit and request expiry.
module pacman_direction_ctrl #(
  parameter int unsigned FRAME_LINE      = 480,
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned PENDING_FRAMES  = 30,
  parameter logic [1:0]  RESET_DIR       = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] svpos,
  input  logic       btn_up,
  input  logic       btn_left,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic [3:0] blocked,
  output logic [1:0] direction,
  output logic       pending_valid,
  output logic [1:0] pending_dir,
  output logic       frame_tick
);

  localparam logic [9:0] FRAME_LINE_C = 10'(FRAME_LINE);
  localparam logic [3:0] DEBOUNCE_C   = 4'(DEBOUNCE_FRAMES);
  localparam logic [5:0] PENDING_C    = 6'(PENDING_FRAMES);

  logic [9:0] svpos_prev_r;
  logic       frame_tick_r;
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] stable_r;
  logic [3:0] cnt_r [4];
  logic [1:0] direction_r;
  logic       pending_valid_r;
  logic [1:0] pending_dir_r;
  logic [5:0] age_r;

  logic [3:0] btn_s;
  logic [3:0] cnt_nxt_s [4];
  logic [3:0] stable_nxt_s;
  logic [3:0] press_s;
  logic       req_valid_s;
  logic [1:0] req_dir_s;
  logic [1:0] dir_nxt_s;
  logic       pv_nxt_s;
  logic [1:0] pd_nxt_s;
  logic [5:0] age_nxt_s;

  // Bit index equals the direction code, so a press index is directly a request.
  assign btn_s = {btn_right, btn_down, btn_left, btn_up};

  // Debounce: a run of DEBOUNCE_FRAMES differing samples flips the stable state.
  always_comb begin
    stable_nxt_s = stable_r;
    press_s      = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt_s[i] = 4'd0;
      if (sync2_r[i] != stable_r[i]) begin
        if ((cnt_r[i] + 4'd1) == DEBOUNCE_C) begin
          cnt_nxt_s[i]    = 4'd0;
          stable_nxt_s[i] = sync2_r[i];
          press_s[i]      = sync2_r[i];
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + 4'd1;
        end
      end else begin
        cnt_nxt_s[i] = 4'd0;
      end
    end
  end

  // Press priority: up > left > down > right.
  always_comb begin
    req_valid_s = |press_s;
    if (press_s[0]) begin
      req_dir_s = 2'd0;
    end else if (press_s[1]) begin
      req_dir_s = 2'd1;
    end else if (press_s[2]) begin
      req_dir_s = 2'd2;
    end else if (press_s[3]) begin
      req_dir_s = 2'd3;
    end else begin
      req_dir_s = 2'd0;
    end
  end

  // Capture, then commit or age the request within the same frame.
  always_comb begin
    dir_nxt_s = direction_r;
    pv_nxt_s  = pending_valid_r;
    pd_nxt_s  = pending_dir_r;
    age_nxt_s = age_r;
    if (req_valid_s) begin
      pv_nxt_s  = 1'b1;
      pd_nxt_s  = req_dir_s;
      age_nxt_s = 6'd0;
    end else begin
      pd_nxt_s = pending_dir_r;
    end
    if (pv_nxt_s && !blocked[pd_nxt_s]) begin
      dir_nxt_s = pd_nxt_s;
      pv_nxt_s  = 1'b0;
      age_nxt_s = 6'd0;
    end else if (pv_nxt_s && !req_valid_s && ((age_r + 6'd1) == PENDING_C)) begin
      pv_nxt_s  = 1'b0;
      age_nxt_s = 6'd0;
    end else if (pv_nxt_s && !req_valid_s) begin
      age_nxt_s = age_r + 6'd1;
    end else begin
      dir_nxt_s = direction_r;
    end
  end

  // State registers; frame-rate state only advances on the frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      svpos_prev_r    <= 10'd0;
      frame_tick_r    <= 1'b0;
      sync1_r         <= 4'b0000;
      sync2_r         <= 4'b0000;
      stable_r        <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= 4'd0;
      end
      direction_r     <= RESET_DIR;
      pending_valid_r <= 1'b0;
      pending_dir_r   <= 2'd0;
      age_r           <= 6'd0;
    end else begin
      svpos_prev_r <= svpos;
      frame_tick_r <= (svpos == FRAME_LINE_C) && (svpos_prev_r != FRAME_LINE_C);
      sync1_r      <= btn_s;
      sync2_r      <= sync1_r;
      if (frame_tick_r) begin
        stable_r <= stable_nxt_s;
        for (int i = 0; i < 4; i++) begin
          cnt_r[i] <= cnt_nxt_s[i];
        end
        direction_r     <= dir_nxt_s;
        pending_valid_r <= pv_nxt_s;
        pending_dir_r   <= pd_nxt_s;
        age_r           <= age_nxt_s;
      end else begin
        stable_r <= stable_r;
      end
    end
  end

  assign direction     = direction_r;
  assign pending_valid = pending_valid_r;
  assign pending_dir   = pending_dir_r;
  assign frame_tick    = frame_tick_r;

endmodule

// File: tb/tb_pacman_direction_ctrl.sv
// Directed bench for pacman_direction_ctrl: a frame-level reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_pacman_direction_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] svpos;
  logic       btn_up, btn_left, btn_down, btn_right;
  logic [3:0] blocked;
  logic [1:0] direction;
  logic       pending_valid;
  logic [1:0] pending_dir;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;
  int tick_cnt = 0;

  pacman_direction_ctrl dut (
    .clk(clk), .reset(reset), .svpos(svpos),
    .btn_up(btn_up), .btn_left(btn_left), .btn_down(btn_down), .btn_right(btn_right),
    .blocked(blocked), .direction(direction), .pending_valid(pending_valid),
    .pending_dir(pending_dir), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model state
  int   m_dir, m_pv, m_pd, m_age, m_tick, m_prev;
  int   stab [4];
  int   streak [4];
  logic [3:0] h1, h2;
  bit   m_started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: at each frame, a button's stable level follows its samples once they
  // have disagreed with it DEBOUNCE (3) frames running; rising flips are presses.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_dir = 3; m_pv = 0; m_pd = 0; m_age = 0; m_tick = 0; m_prev = 0;
      for (int i = 0; i < 4; i++) begin stab[i] = 0; streak[i] = 0; end
      h1 = 4'b0; h2 = 4'b0;
      m_started = 1'b1;
    end else begin
      if (m_tick == 1) begin
        int req;
        req = -1;
        for (int i = 0; i < 4; i++) begin
          if (int'(h2[i]) != stab[i]) begin
            streak[i]++;
            if (streak[i] >= 3) begin
              stab[i] = int'(h2[i]);
              streak[i] = 0;
              if (stab[i] == 1 && req < 0) req = i;
            end
          end else begin
            streak[i] = 0;
          end
        end
        if (req >= 0) begin m_pv = 1; m_pd = req; m_age = 0; end
        if (m_pv == 1 && blocked[m_pd] == 1'b0) begin
          m_dir = m_pd; m_pv = 0; m_age = 0;
        end else if (m_pv == 1 && req < 0) begin
          m_age++;
          if (m_age >= 30) begin m_pv = 0; m_age = 0; end
        end
      end
      m_tick = (svpos == 10'd480 && m_prev != 480) ? 1 : 0;
      m_prev = int'(svpos);
      h2 = h1;
      h1 = {btn_right, btn_down, btn_left, btn_up};
    end
  end

  // Compare every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      check("dir",  int'(direction),     m_dir);
      check("pv",   int'(pending_valid), m_pv);
      check("pd",   int'(pending_dir),   m_pd);
      check("tick", int'(frame_tick),    m_tick);
      tick_cnt += int'(frame_tick);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Short frame: blank lines, then the sample line for a few cycles.
  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      svpos = 10'd0;   cycles(6);
      svpos = 10'd480; cycles(4);
    end
    svpos = 10'd0;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    @(negedge clk);
    check(name, act, exp);
  endtask

  initial begin
    reset = 1'b1; svpos = 10'd0; blocked = 4'b0000;
    btn_up = 1'b0; btn_left = 1'b0; btn_down = 1'b0; btn_right = 1'b0;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dir", int'(direction), 3);
    check("rst_pv", int'(pending_valid), 0);
    #2;

    // Idle sweeps and a long hold on the sample line.
    for (int s = 0; s < 2; s++) begin
      tick_cnt = 0;
      for (int v = 0; v < 525; v++) begin
        @(posedge clk); #2; svpos = 10'(v);
      end
      cycles(2);
      check("sweep_ticks", tick_cnt, 1);
    end
    tick_cnt = 0;
    svpos = 10'd480; cycles(800);
    svpos = 10'd0;   cycles(3);
    check("hold_ticks", tick_cnt, 1);
    check("idle_dir", int'(direction), 3);

    // Up held three frames commits on the third tick; holding adds nothing.
    btn_up = 1'b1; frames(3);
    lit("up_dir", int'(direction), 0);
    check("up_pv", int'(pending_valid), 0);
    frames(3);
    lit("up_hold_dir", int'(direction), 0);
    btn_up = 1'b0; frames(3);

    // Two-frame glitch on left is filtered out.
    btn_left = 1'b1; frames(2);
    btn_left = 1'b0; frames(3);
    lit("glitch_dir", int'(direction), 0);
    check("glitch_pv", int'(pending_valid), 0);

    // Down against a wall waits, then commits once the wall clears on frame 10.
    blocked = 4'b0100; btn_down = 1'b1; frames(3);
    lit("blk_pv", int'(pending_valid), 1);
    check("blk_pd", int'(pending_dir), 2);
    check("blk_dir", int'(direction), 0);
    btn_down = 1'b0; frames(6);
    lit("blk9_pv", int'(pending_valid), 1);
    blocked = 4'b0000; frames(1);
    lit("clr_dir", int'(direction), 2);
    check("clr_pv", int'(pending_valid), 0);

    // A blocked request expires on the 30th tick after capture.
    blocked = 4'b0100; btn_down = 1'b1; frames(3);
    lit("exp_cap_pv", int'(pending_valid), 1);
    btn_down = 1'b0; frames(29);
    lit("exp29_pv", int'(pending_valid), 1);
    frames(1);
    lit("exp30_pv", int'(pending_valid), 0);
    check("exp_dir", int'(direction), 2);

    // Simultaneous left+right picks left; reset mid-pending clears everything.
    blocked = 4'b1111; btn_left = 1'b1; btn_right = 1'b1; frames(3);
    lit("lr_pv", int'(pending_valid), 1);
    check("lr_pd", int'(pending_dir), 1);
    #2;
    reset = 1'b1; cycles(1);
    lit("mid_rst_dir", int'(direction), 3);
    check("mid_rst_pv", int'(pending_valid), 0);
    check("mid_rst_pd", int'(pending_dir), 0);
    check("mid_rst_tick", int'(frame_tick), 0);
    #2;
    reset = 1'b0; btn_left = 1'b0; btn_right = 1'b0; blocked = 4'b0000;
    frames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pacman_direction_ctrl.md
Name: pacman_direction_ctrl

Overview:
- Upstream stage of the Pacman sprite/mover; its output drives the mover's 2-bit `direction` input.
- Samples four raw active-high buttons once per frame and debounces them. Buffers the player's most recent turn request.
- Commits the request to `direction` only when the maze wall mask allows it. Expires the request after a timeout.
- Direction encoding, as the mover uses it: 0 = up, 1 = left, 2 = down, 3 = right.

Parameters:
- FRAME_LINE, 480: value of `svpos` that marks the frame sample point.
- DEBOUNCE_FRAMES, 3: consecutive identical frame samples needed before a button is considered stable (range 1..15).
- PENDING_FRAMES, 30: frames a blocked request is held before it is discarded (range 1..63).
- RESET_DIR, 3: `direction` value after reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- svpos  input  10  current vertical scan position
- btn_up  input  1  raw button, active high, asynchronous to frame
- btn_left  input  1  raw button
- btn_down  input  1  raw button
- btn_right  input  1  raw button
- blocked  input  4  wall mask from maze logic; bit d=1 means direction d is blocked at Pacman's current cell
- direction  output  2  committed direction, feeds the mover
- pending_valid  output  1  a buffered request is waiting
- pending_dir  output  2  direction of the buffered request
- frame_tick  output  1  one-cycle pulse per frame

Behaviour:
- All state updates on posedge `clk`. `reset` has priority over every other event. Reset mid-operation discards everything.
- Reset values:
  - `direction` = RESET_DIR
  - `pending_valid` = 0, `pending_dir` = 0, `frame_tick` = 0
  - debounce counters = 0, stable button state = 0
  - `svpos` history register = 0, pending age = 0
- Frame strobe:
  - `frame_tick` = 1 for exactly one cycle when `svpos` == FRAME_LINE and the previous cycle's `svpos` != FRAME_LINE (registered edge detect).
  - Holding `svpos` at FRAME_LINE for many cycles yields one pulse.
- Button sync and debounce:
  - Buttons pass through a 2-flop synchronizer.
  - On each `frame_tick`, a synchronized button that differs from its stable state increments its 4-bit counter. A button equal to its stable state clears its counter.
  - When a counter reaches DEBOUNCE_FRAMES, the stable state flips and the counter clears.
  - A 0→1 stable transition is a "press event".
- Request capture (on a `frame_tick` with ≥1 press event):
  - Priority up > left > down > right selects one direction r.
  - `pending_dir` <= r, `pending_valid` <= 1, age <= 0.
  - A newer press overwrites an older pending request.
- Commit (evaluated on `frame_tick`, after capture in the same tick; a request captured this tick may commit this tick):
  - If `pending_valid` and `blocked[pending_dir]` = 0: `direction` <= `pending_dir`, `pending_valid` <= 0.
  - A reversal (opposite of `direction`) follows the same rule; it gets no special case.
  - A request equal to the current `direction` commits, leaving `direction` unchanged, and clears pending.
- Expiry:
  - While pending is still blocked, age increments per `frame_tick` (6-bit counter).
  - When age reaches PENDING_FRAMES, `pending_valid` <= 0.
  - A fresh press in the same tick wins over expiry and resets age.
- `direction` never changes except on `frame_tick` or `reset`.
- `blocked` is sampled only on `frame_tick`. Blocking of the current direction does not alter `direction`; stopping is the mover's job.
- Holding a button produces only one press event. Re-pressing requires a stable release then a stable press.

Test Plan:
- Reset, then drive `svpos` 0..524 repeatedly with no buttons → `direction` = 3, `pending_valid` = 0; exactly one `frame_tick` per sweep, including when `svpos` is held at 480 for 800 cycles.
- Hold `btn_up` for 3 frames, `blocked` = 0 → `pending_valid` rises on the 3rd `frame_tick` and commits in the same tick; `direction` = 0 after it; holding further causes no new event.
- Glitch `btn_left` high for 2 frames then low (DEBOUNCE_FRAMES = 3) → no press event, `direction` unchanged.
- Press `btn_down` with `blocked` = 4'b0100 → `pending_valid` = 1, `pending_dir` = 2, `direction` unchanged. Clear `blocked` at frame 10 → `direction` = 2 on that tick, pending cleared.
- Keep `blocked[2]` = 1 after a down press → `pending_valid` drops on the 30th `frame_tick` after capture; `direction` unchanged.
- Simultaneous stable presses of `btn_left` and `btn_right` → `pending_dir` = 1. Assert `reset` mid-pending → all outputs return to reset values next cycle.
